// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared state enum and size defaults for the cipher sequencer
package cipher_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KEY,
        ST_LOAD_MSG,
        ST_ENCRYPT,
        ST_SHIFT_OUT
    } seq_state_t;

    localparam int CIPHER_MSG_SIZE = 128;
    localparam int CIPHER_KEY_SIZE = 8;
    localparam int CIPHER_CNT_W    = $clog2(CIPHER_MSG_SIZE);

endpackage

// File: rtl/seq_bit_counter.sv
// rtl/seq_bit_counter.sv - phase bit counter with clear, increment and runtime terminal compare
module seq_bit_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         last_o
);

    logic [W-1:0] cnt;

    // clr and en together load 1: the entry edge of a load phase already counts a bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || en) begin
            cnt <= (clr ? '0 : cnt) + W'(en);
        end
    end

    assign last_o = (cnt == limit);

endmodule

// File: rtl/cipher_seq_ctrl.sv
// rtl/cipher_seq_ctrl.sv - load/encrypt/shift-out sequencer; CIPHER_SEQ_ERR_EN builds the sticky err_o flag
module cipher_seq_ctrl
    import cipher_pkg::*;
#(
    parameter int MSG_SIZE = CIPHER_MSG_SIZE,
    parameter int KEY_SIZE = CIPHER_KEY_SIZE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic key_en_i,
    input  logic msg_en_i,
    output logic key_shift_o,
    output logic msg_shift_o,
    output logic xor_go_o,
    output logic out_shift_o,
    output logic out_valid_o,
    output logic key_valid_o,
    output logic busy_o,
    output logic err_o
);

    localparam int               CNT_W    = $clog2(MSG_SIZE);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_SIZE - 1);
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_SIZE - 1);

    seq_state_t       state, state_n;
    logic             key_valid, key_valid_n;
    logic             cnt_clr, cnt_en, cnt_last;
    logic [CNT_W-1:0] cnt_limit;
    logic             err_set, err_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            key_valid <= key_valid_n;
        end
    end

    assign cnt_limit = (state == ST_LOAD_KEY) ? KEY_LAST : MSG_LAST;

    seq_bit_counter #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (cnt_limit),
        .last_o (cnt_last)
    );

    // ena low leaves every default in place, which freezes state, counter and flags
    always_comb begin
        state_n     = state;
        key_valid_n = key_valid;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        if (ena) begin
            case (state)
                ST_IDLE: begin
                    if (key_en_i) begin
                        state_n     = ST_LOAD_KEY;
                        key_valid_n = 1'b0;
                        cnt_clr     = 1'b1;
                        cnt_en      = 1'b1;
                    end else if (msg_en_i) begin
                        if (key_valid) begin
                            state_n = ST_LOAD_MSG;
                            cnt_clr = 1'b1;
                            cnt_en  = 1'b1;
                        end else begin
                            err_set = 1'b1;
                        end
                    end
                end
                ST_LOAD_KEY: begin
                    if (!key_en_i) begin
                        state_n = ST_IDLE;
                        cnt_clr = 1'b1;
                        err_set = 1'b1;
                    end else if (cnt_last) begin
                        state_n     = ST_IDLE;
                        key_valid_n = 1'b1;
                        cnt_clr     = 1'b1;
                        err_clr     = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_LOAD_MSG: begin
                    if (!msg_en_i) begin
                        state_n = ST_IDLE;
                        cnt_clr = 1'b1;
                        err_set = 1'b1;
                    end else if (cnt_last) begin
                        state_n = ST_ENCRYPT;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                ST_ENCRYPT: begin
                    state_n = ST_SHIFT_OUT;
                    cnt_clr = 1'b1;
                end
                ST_SHIFT_OUT: begin
                    if (cnt_last) begin
                        state_n = ST_IDLE;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    assign key_shift_o = ena & key_en_i & ((state == ST_IDLE) | (state == ST_LOAD_KEY));
    assign msg_shift_o = ena & msg_en_i & (((state == ST_IDLE) & key_valid) | (state == ST_LOAD_MSG));
    assign xor_go_o    = ena & (state == ST_ENCRYPT);
    assign out_shift_o = ena & (state == ST_SHIFT_OUT);
    assign out_valid_o = (state == ST_SHIFT_OUT);
    assign busy_o      = (state != ST_IDLE);
    assign key_valid_o = key_valid;

`ifdef CIPHER_SEQ_ERR_EN
    logic err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    assign err_o = err;
`else
    logic unused_err;
    assign unused_err = err_set ^ err_clr;
    assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// tb/tb_cipher_seq_ctrl.sv - randomized self-checking bench for cipher_seq_ctrl
module tb_cipher_seq_ctrl;

    localparam int MSG = 128;
    localparam int KEY = 8;
`ifdef CIPHER_SEQ_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int P_IDLE = 0, P_KEY = 1, P_MSG = 2, P_ENC = 3, P_OUT = 4;

    localparam logic [127:0] MSG1 = 128'hD34B8F12A1C56D3E4FA12B6C7D9E2F3A;
    localparam logic [127:0] CT1  = 128'h76EE2AB70460C89BEA048EC9D83B8A9F;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic key_en = 1'b0;
    logic msg_en = 1'b0;
    logic sdata = 1'b0;

    logic key_shift_o, msg_shift_o, xor_go_o, out_shift_o;
    logic out_valid_o, key_valid_o, busy_o, err_o;

    always #5 clk = ~clk;

    cipher_seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .key_en_i    (key_en),
        .msg_en_i    (msg_en),
        .key_shift_o (key_shift_o),
        .msg_shift_o (msg_shift_o),
        .xor_go_o    (xor_go_o),
        .out_shift_o (out_shift_o),
        .out_valid_o (out_valid_o),
        .key_valid_o (key_valid_o),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: phase, bits handled in this phase, and the data it was fed
    int           m_phase = P_IDLE;
    int           m_n = 0;
    logic         m_keyok = 1'b0;
    logic         m_err = 1'b0;
    logic [7:0]   m_key = '0;
    logic [127:0] m_msg = '0;
    logic [127:0] m_ct = '0;

    // bench-side datapath driven by the strobes, to rebuild the serial stream
    logic [7:0]   d_key = '0;
    logic [127:0] d_msg = '0;
    logic [127:0] d_ct = '0;
    logic [127:0] rx = '0;
    logic [127:0] last_rx = '0;
    logic s_ks = 1'b0, s_ms = 1'b0, s_xg = 1'b0, s_os = 1'b0, s_ov = 1'b0;
    int cnt_ks = 0, cnt_xg = 0, cnt_os = 0, cnt_ov = 0;

    always @(negedge clk) begin
        s_ks = key_shift_o;
        s_ms = msg_shift_o;
        s_xg = xor_go_o;
        s_os = out_shift_o;
        s_ov = out_valid_o;
        if (rst_n) begin
            check("key_shift", key_shift_o,
                  ena & key_en & ((m_phase == P_IDLE) | (m_phase == P_KEY)));
            check("msg_shift", msg_shift_o,
                  ena & msg_en & (((m_phase == P_IDLE) & m_keyok) | (m_phase == P_MSG)));
            check("xor_go",    xor_go_o,    ena & (m_phase == P_ENC));
            check("out_shift", out_shift_o, ena & (m_phase == P_OUT));
            check("out_valid", out_valid_o, m_phase == P_OUT);
            check("key_valid", key_valid_o, m_keyok);
            check("busy",      busy_o,      m_phase != P_IDLE);
            check("err",       err_o,       m_err);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE;
            m_n     = 0;
            m_keyok = 1'b0;
            m_err   = 1'b0;
        end else begin
            if (s_ks) begin d_key = {d_key[6:0], sdata}; cnt_ks++; end
            if (s_ms) d_msg = {d_msg[126:0], sdata};
            if (s_xg) begin d_ct = d_msg ^ {16{d_key}}; rx = '0; cnt_xg++; end
            if (s_os) begin rx = {rx[126:0], d_ct[127]}; d_ct = {d_ct[126:0], 1'b0}; cnt_os++; end
            if (s_ov) cnt_ov++;
            if (ena) begin
                case (m_phase)
                    P_IDLE: begin
                        if (key_en) begin
                            m_phase = P_KEY; m_n = 1; m_keyok = 1'b0;
                            m_key = {m_key[6:0], sdata};
                        end else if (msg_en) begin
                            if (m_keyok) begin
                                m_phase = P_MSG; m_n = 1;
                                m_msg = {m_msg[126:0], sdata};
                            end else if (ERR_EN) begin
                                m_err = 1'b1;
                            end
                        end
                    end
                    P_KEY: begin
                        if (key_en) begin
                            m_key = {m_key[6:0], sdata};
                            m_n++;
                            if (m_n == KEY) begin
                                m_phase = P_IDLE; m_keyok = 1'b1; m_err = 1'b0;
                            end
                        end else begin
                            m_phase = P_IDLE;
                            if (ERR_EN) m_err = 1'b1;
                        end
                    end
                    P_MSG: begin
                        if (msg_en) begin
                            m_msg = {m_msg[126:0], sdata};
                            m_n++;
                            if (m_n == MSG) begin
                                m_phase = P_ENC;
                                m_ct = m_msg ^ {16{m_key}};
                            end
                        end else begin
                            m_phase = P_IDLE;
                            if (ERR_EN) m_err = 1'b1;
                        end
                    end
                    P_ENC: begin
                        m_phase = P_OUT; m_n = 0;
                    end
                    default: begin
                        m_n++;
                        if (m_n == MSG) begin
                            m_phase = P_IDLE;
                            check("ciphertext_stream", rx, m_ct);
                            last_rx = rx;
                        end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [7:0] k, input int drop_at, input bit gaps);
        for (int i = 0; i < KEY; i++) begin
            if (i == drop_at) begin
                key_en = 1'b0;
                tick();
                return;
            end
            key_en = 1'b1;
            sdata  = k[7-i];
            if (gaps && $urandom_range(0, 3) == 0) begin
                ena = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                ena = 1'b1;
            end
            tick();
        end
        key_en = 1'b0;
        sdata  = 1'b0;
    endtask

    task automatic load_msg(input logic [127:0] m, input int drop_at, input bit gaps);
        for (int i = 0; i < MSG; i++) begin
            if (i == drop_at) begin
                msg_en = 1'b0;
                tick();
                return;
            end
            msg_en = 1'b1;
            sdata  = m[127-i];
            if (gaps && $urandom_range(0, 7) == 0) begin
                ena = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                ena = 1'b1;
            end
            tick();
        end
        msg_en = 1'b0;
        sdata  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        while (busy_o && budget > 0) begin
            tick();
            budget--;
        end
        check("busy_timeout", busy_o, 1'b0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [7:0]   k;
        logic [127:0] m;
        int           b;

        rst_n = 1'b0;
        ena   = 1'b1;
        repeat (3) tick();
        check("reset_outputs",
              {key_shift_o, msg_shift_o, xor_go_o, out_shift_o, out_valid_o, key_valid_o, busy_o, err_o},
              8'h00);
        rst_n = 1'b1;
        tick();

        cnt_ks = 0;
        load_key(8'hA5, -1, 1'b0);
        check("key_shift_edges", cnt_ks, 8);
        check("key_valid_after_load", key_valid_o, 1'b1);
        check("busy_after_key", busy_o, 1'b0);
        repeat (5) tick();

        cnt_xg = 0; cnt_ov = 0; cnt_os = 0;
        load_msg(MSG1, -1, 1'b0);
        wait_idle(300);
        check("xor_go_pulses", cnt_xg, 1);
        check("out_valid_cycles", cnt_ov, 128);
        check("out_shift_cycles", cnt_os, 128);
        check("model_ct_literal", m_ct, CT1);
        check("stream_ct_literal", last_rx, CT1);

        m = rand128();
        load_msg(m, -1, 1'b1);
        wait_idle(300);
        check("retained_key_ct", last_rx, m ^ {16{8'hA5}});

        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        msg_en = 1'b1;
        sdata  = 1'b1;
        #1;
        check("msg_shift_no_key", msg_shift_o, 1'b0);
        repeat (3) tick();
        msg_en = 1'b0;
        check("err_msg_before_key", err_o, ERR_EN);
        check("busy_msg_before_key", busy_o, 1'b0);
        load_key(8'h3C, -1, 1'b0);
        check("err_cleared_by_key", err_o, 1'b0);

        load_key(8'h5A, 5, 1'b0);
        check("abort_key_valid", key_valid_o, 1'b0);
        check("abort_key_err", err_o, ERR_EN);
        check("abort_key_busy", busy_o, 1'b0);

        load_key(8'hA5, -1, 1'b0);
        cnt_os = 0;
        load_msg(rand128(), -1, 1'b0);
        b = 300;
        while (cnt_os < 40 && b > 0) begin
            tick();
            b--;
        end
        check("reach_bit40", cnt_os >= 40, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {key_shift_o, msg_shift_o, xor_go_o, out_shift_o, out_valid_o, busy_o, err_o}, 7'h00);
        check("midreset_key_valid", key_valid_o, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        k = 8'($urandom());
        m = rand128();
        load_key(k, -1, 1'b1);
        load_msg(m, -1, 1'b1);
        wait_idle(400);
        check("post_reset_ct", last_rx, m ^ {16{k}});

        for (int it = 0; it < 6; it++) begin
            k = 8'($urandom());
            m = rand128();
            if ($urandom_range(0, 2) == 0) load_key(8'($urandom()), $urandom_range(1, 7), 1'b0);
            load_key(k, -1, 1'b1);
            if ($urandom_range(0, 2) == 0) load_msg(rand128(), $urandom_range(1, 127), 1'b1);
            repeat ($urandom_range(0, 3)) tick();
            load_msg(m, -1, 1'b1);
            wait_idle(400);
            check("random_ct", last_rx, m ^ {16{k}});
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cipher_seq_ctrl.md
# cipher_seq_ctrl

Sequencing controller for the serial XOR-cipher datapath inside `tt_um_franco_mezzarapa`. It decodes the pin-level load strobes (key-load enable, message-load enable, serial data) into shift and capture strobes for the key and message registers. It fires the one-cycle encrypt, then paces the MSB-first serial ciphertext output with a valid flag. It owns all phase and bit counting, so the datapath is pure registers plus XOR.

## Interface
Parameters:
- `MSG_SIZE`, 128: message/ciphertext length in bits; a multiple of `KEY_SIZE`.
- `KEY_SIZE`, 8: key length in bits.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  tile enable; low freezes all state and forces every strobe low.
- `key_en_i`  in  1  key-load window (pin ui_in[1]).
- `msg_en_i`  in  1  message-load window (pin ui_in[2]).
- `key_shift_o`  out  1  key register shifts in the serial bit at this edge.
- `msg_shift_o`  out  1  message register shifts in the serial bit at this edge.
- `xor_go_o`  out  1  one-cycle pulse; datapath latches message XOR repeated key.
- `out_shift_o`  out  1  ciphertext register shifts left at this edge.
- `out_valid_o`  out  1  ciphertext bit on the serial output is valid (pin uo_out[1]).
- `key_valid_o`  out  1  a complete key is held.
- `busy_o`  out  1  state is not IDLE.
- `err_o`  out  1  sticky protocol error (see Configuration).

## Operation
- States: IDLE, LOAD_KEY, LOAD_MSG, ENCRYPT, SHIFT_OUT. One bit counter of width $clog2(MSG_SIZE), shared by all phases and cleared on every phase entry.
- `key_shift_o` = ena & key_en_i & (IDLE|LOAD_KEY). This strobe is combinational, so a bit is captured on the same edge its enable is first seen.
- `msg_shift_o` = ena & msg_en_i & ((IDLE & key_valid)|LOAD_MSG). This strobe is also combinational.
- IDLE:
  - key_en_i → LOAD_KEY with counter=1, and key_valid is cleared.
  - msg_en_i with key_valid → LOAD_MSG with counter=1.
  - msg_en_i without key_valid → stay in IDLE and set err.
  - key_en_i and msg_en_i together: key wins.
- LOAD_KEY:
  - Each key_en_i cycle increments the counter.
  - On the bit where counter==KEY_SIZE-1: set key_valid and go to IDLE.
  - key_en_i low before the full count: abort to IDLE, key_valid stays 0, set err.
- LOAD_MSG: same rule with MSG_SIZE. A full count goes to ENCRYPT; an early drop aborts to IDLE and sets err. key_valid is unaffected in both cases.
- ENCRYPT: `xor_go_o`=1 for exactly one cycle, then SHIFT_OUT.
- SHIFT_OUT:
  - `out_valid_o`=`out_shift_o`=1 for exactly MSG_SIZE cycles.
  - The counter wraps from MSG_SIZE-1 to 0, and the state returns to IDLE.
  - key_en_i and msg_en_i are ignored here.
- key_valid persists after an output phase, so further messages need no key reload.
- `out_valid_o` and `busy_o` are decoded from the registered state and are glitch-free.

## Timing
- Reset values: state IDLE, counter 0, key_valid 0, err 0; all outputs 0.
- Reset mid-operation returns to IDLE immediately (asynchronous) and drops key_valid. Datapath contents are don't-care.
- Key load takes KEY_SIZE consecutive cycles of key_en_i; message load takes MSG_SIZE.
- Edge N samples the last message bit. `xor_go_o` is high during cycle N→N+1. `out_valid_o` is high from edge N+1 through edge N+1+MSG_SIZE.
- The first ciphertext bit (MSB) is valid in the first `out_valid_o` cycle. The consumer samples on each rising edge while `out_valid_o`=1.
- ena low for any cycles: counter, state and flags hold. Loading resumes when ena returns; a held enable continues the load rather than aborting it.
- Back-to-back: a new key_en_i/msg_en_i is accepted in the first IDLE cycle after SHIFT_OUT.

## Configuration
- `CIPHER_SEQ_ERR_EN` defined:
  - Early-drop aborts and msg-before-key set `err_o`.
  - `err_o` stays set until reset or the next successful key load.
- Undefined:
  - Aborts still return to IDLE silently, with identical state behaviour.
  - `err_o` is tied to 0 and its flop is not built.

## Structure
- Shared package `cipher_pkg`:
  - state enum `seq_state_t`;
  - defaults `CIPHER_MSG_SIZE`=128 and `CIPHER_KEY_SIZE`=8;
  - `CIPHER_CNT_W`=$clog2(CIPHER_MSG_SIZE).
- One sub-module `seq_bit_counter`: clear, enable, terminal-count compare against a runtime limit, and a `last_o` flag.

## Test plan
- Reset, then load key 0xA5 MSB-first over 8 cycles → `key_shift_o` high for exactly 8 edges and `key_valid_o`=1 after the 8th; `busy_o` back to 0.
- Wait 5 cycles, then load message 0xD34B8F12A1C56D3E4FA12B6C7D9E2F3A → `xor_go_o` pulses once, then `out_valid_o` is high for exactly 128 cycles. The serial stream rebuilds to 0x76EE2AB70460C89BEA048EC9D83B8A9F.
- Second message with no key reload → correct ciphertext under the retained key 0xA5.
- msg_en_i raised before any key, with the macro on → `err_o`=1, `msg_shift_o` stays 0, state remains IDLE.
- key_en_i dropped after 5 bits → abort to IDLE, `key_valid_o`=0, `err_o`=1 (macro on) or 0 (macro off).
- Assert rst_n low at output bit 40, then release → all outputs 0 immediately, `key_valid_o`=0, and a fresh key+message sequence passes.
